// File: rtl/display_pkg.sv
// display_pkg -- shared definitions for the seven-segment display path.
//
// Holds the ten legal digit patterns (bit6 = segment a ... bit0 = segment g,
// active-high) used both by the display driver and by display_decoder, the
// decoder FSM state type, and a digit -> pattern helper for the driver side.
package display_pkg;

  localparam logic [6:0] NUM_0 = 7'b1111110;
  localparam logic [6:0] NUM_1 = 7'b0110000;
  localparam logic [6:0] NUM_2 = 7'b1101101;
  localparam logic [6:0] NUM_3 = 7'b1111001;
  localparam logic [6:0] NUM_4 = 7'b0110011;
  localparam logic [6:0] NUM_5 = 7'b1011011;
  localparam logic [6:0] NUM_6 = 7'b1011111;
  localparam logic [6:0] NUM_7 = 7'b1110000;
  localparam logic [6:0] NUM_8 = 7'b1111111;
  localparam logic [6:0] NUM_9 = 7'b1110011;

  // Decoder frame FSM: waiting, settling tens, tens held, settling ones.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE_T = 2'd1,
    HAVE_T   = 2'd2,
    SETTLE_O = 2'd3
  } state_t;

  // Digit to segment pattern; out-of-range digits blank the display.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = NUM_0;
      4'd1:    seg = NUM_1;
      4'd2:    seg = NUM_2;
      4'd3:    seg = NUM_3;
      4'd4:    seg = NUM_4;
      4'd5:    seg = NUM_5;
      4'd6:    seg = NUM_6;
      4'd7:    seg = NUM_7;
      4'd8:    seg = NUM_8;
      4'd9:    seg = NUM_9;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_decoder_seg_to_bcd.sv
// seg_to_bcd -- combinational segment pattern to BCD digit.
//
// Ports:
//   pattern  in   7  segment pattern, bit6 = a ... bit0 = g
//   legal    out  1  pattern is exactly one of NUM_0..NUM_9
//   digit    out  4  decoded digit (0 when not legal)
module seg_to_bcd
  import display_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] digit
);

  // Exact-match lookup; every other pattern, including blank, is illegal.
  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (pattern)
      NUM_0:   digit = 4'd0;
      NUM_1:   digit = 4'd1;
      NUM_2:   digit = 4'd2;
      NUM_3:   digit = 4'd3;
      NUM_4:   digit = 4'd4;
      NUM_5:   digit = 4'd5;
      NUM_6:   digit = 4'd6;
      NUM_7:   digit = 4'd7;
      NUM_8:   digit = 4'd8;
      NUM_9:   digit = 4'd9;
      default: begin
        legal = 1'b0;
        digit = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/display_decoder.sv
// display_decoder -- recovers a two-digit value (0..99) from a multiplexed
// seven-segment display by sniffing its segment and digit-select lines.
//
// A frame is a tens phase (DIGIT_SELECT low) followed by a ones phase
// (DIGIT_SELECT high). In each phase the pattern must hold unchanged for
// SETTLE_CYCLES cycles before it is captured.
//
// Ports:
//   CLK           in   1  clock, all flops on the rising edge
//   RST_N         in   1  asynchronous active-low reset
//   SEGMENTS      in   7  segment lines, bit6 = a ... bit0 = g, active-high
//   DIGIT_SELECT  in   1  0 = tens digit shown, 1 = ones digit shown
//   DATA_OUT      out  8  last decoded value
//   DATA_VALID    out  1  one-cycle pulse when DATA_OUT updates
//   SEG_ERROR     out  1  one-cycle pulse when a captured pattern is illegal
//   STALE         out  1  no completed frame for TIMEOUT_CYCLES cycles
//
// Build option: define DISPLAY_DECODER_STALE_EN to build the stale timeout;
// otherwise STALE is tied low and TIMEOUT_CYCLES has no effect.
module display_decoder
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] SEGMENTS,
  input  logic       DIGIT_SELECT,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID,
  output logic       SEG_ERROR,
  output logic       STALE
);

  // The settle counter only needs to reach SETTLE_CYCLES-1: capture happens
  // on the edge where it would reach SETTLE_CYCLES.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CAPTURE_AT = CNT_W'(SETTLE_CYCLES - 1);

  logic [6:0]       seg_meta_r;
  logic [6:0]       seg_sync_r;
  logic [6:0]       seg_prev_r;
  logic             sel_meta_r;
  logic             sel_sync_r;
  logic             sel_prev_r;

  logic             sel_rise_s;
  logic             sel_fall_s;
  logic             seg_change_s;
  logic             legal_s;
  logic [3:0]       digit_s;
  logic [7:0]       data_value_s;

  state_t           state_r;
  state_t           state_n;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n;
  logic             tens_load_s;
  logic             data_load_s;
  logic             err_s;

  logic [3:0]       tens_r;
  logic [7:0]       data_out_r;
  logic             data_valid_r;
  logic             seg_error_r;

  // Two-flop synchronizers plus one history stage for edge/change detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_meta_r <= 7'd0;
      seg_sync_r <= 7'd0;
      seg_prev_r <= 7'd0;
      sel_meta_r <= 1'b0;
      sel_sync_r <= 1'b0;
      sel_prev_r <= 1'b0;
    end else begin
      seg_meta_r <= SEGMENTS;
      seg_sync_r <= seg_meta_r;
      seg_prev_r <= seg_sync_r;
      sel_meta_r <= DIGIT_SELECT;
      sel_sync_r <= sel_meta_r;
      sel_prev_r <= sel_sync_r;
    end
  end

  assign sel_rise_s   = sel_sync_r & ~sel_prev_r;
  assign sel_fall_s   = ~sel_sync_r & sel_prev_r;
  assign seg_change_s = (seg_sync_r != seg_prev_r);

  seg_to_bcd u_seg_to_bcd (
    .pattern (seg_sync_r),
    .legal   (legal_s),
    .digit   (digit_s)
  );

  // tens <= 9 and ones <= 9, so the result never exceeds 99 in 8 bits.
  assign data_value_s = (8'(tens_r) * 8'd10) + 8'(digit_s);

  // FSM state and settle counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state and capture decisions. In the settle states a select edge
  // takes priority over capture and is treated exactly as it would be from
  // IDLE: falling restarts the tens phase, rising is dropped.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    tens_load_s = 1'b0;
    data_load_s = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_fall_s) begin
          state_n = SETTLE_T;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      SETTLE_T, SETTLE_O: begin
        if (sel_fall_s) begin
          state_n = SETTLE_T;
          cnt_n   = '0;
        end else if (sel_rise_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (seg_change_s) begin
          cnt_n = '0;
        end else if (cnt_r == CAPTURE_AT) begin
          cnt_n = '0;
          if (!legal_s) begin
            err_s   = 1'b1;
            state_n = IDLE;
          end else if (state_r == SETTLE_T) begin
            tens_load_s = 1'b1;
            state_n     = HAVE_T;
          end else begin
            data_load_s = 1'b1;
            state_n     = IDLE;
          end
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      HAVE_T: begin
        if (sel_rise_s) begin
          state_n = SETTLE_O;
          cnt_n   = '0;
        end else if (sel_fall_s) begin
          state_n = SETTLE_T;
          cnt_n   = '0;
        end else begin
          state_n = HAVE_T;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Captured digits and registered result/pulse outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tens_r       <= 4'd0;
      data_out_r   <= 8'd0;
      data_valid_r <= 1'b0;
      seg_error_r  <= 1'b0;
    end else begin
      data_valid_r <= data_load_s;
      seg_error_r  <= err_s;
      if (tens_load_s) begin
        tens_r <= digit_s;
      end
      if (data_load_s) begin
        data_out_r <= data_value_s;
      end
    end
  end

  assign DATA_OUT   = data_out_r;
  assign DATA_VALID = data_valid_r;
  assign SEG_ERROR  = seg_error_r;

`ifdef DISPLAY_DECODER_STALE_EN
  localparam int STALE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT_CYCLES);

  logic [STALE_W-1:0] stale_cnt_r;
  logic [STALE_W-1:0] stale_cnt_n;
  logic               stale_r;

  // Stale counter clears in step with the DATA_VALID pulse and saturates.
  always_comb begin
    stale_cnt_n = stale_cnt_r;
    if (data_load_s) begin
      stale_cnt_n = '0;
    end else if (stale_cnt_r != STALE_MAX) begin
      stale_cnt_n = stale_cnt_r + STALE_W'(1);
    end else begin
      stale_cnt_n = STALE_MAX;
    end
  end

  // Stale counter and its registered flag, kept equal to (count == max).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stale_cnt_r <= '0;
      stale_r     <= 1'b0;
    end else begin
      stale_cnt_r <= stale_cnt_n;
      stale_r     <= (stale_cnt_n == STALE_MAX);
    end
  end

  assign STALE = stale_r;
`else
  assign STALE = 1'b0;
`endif

endmodule

// File: tb/tb_display_decoder.sv
// tb_display_decoder -- self-checking bench for display_decoder.
// Frames are driven on the falling clock edge; outputs are sampled 1 time
// unit after the rising edge. Expected values come from a digit table and
// the frame rules (value = tens*10 + ones, illegal patterns error out).
module tb_display_decoder;

  localparam int S  = 4;
  localparam int TO = 1000;

  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
  };

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [6:0] SEGMENTS = 7'd0;
  logic       DIGIT_SELECT = 1'b0;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       SEG_ERROR;
  logic       STALE;

  int n_checks = 0;
  int n_fails = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = -1;
  int rise_cyc = 0;
  int model_data = 0;

  display_decoder #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .SEGMENTS     (SEGMENTS),
    .DIGIT_SELECT (DIGIT_SELECT),
    .DATA_OUT     (DATA_OUT),
    .DATA_VALID   (DATA_VALID),
    .SEG_ERROR    (SEG_ERROR),
    .STALE        (STALE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: counts DATA_VALID / SEG_ERROR cycles and notes when.
  always @(posedge CLK) begin
    #1;
    if (DATA_VALID === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (SEG_ERROR === 1'b1) err_cnt++;
  end

  function automatic int model_digit(input logic [6:0] p);
    int r;
    r = -1;
    for (int i = 0; i < 10; i++) if (SEG_TAB[i] == p) r = i;
    return r;
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] p;
    p = 7'($urandom_range(0, 127));
    while (model_digit(p) >= 0) p = 7'($urandom_range(0, 127));
    return p;
  endfunction

  task automatic hold(input logic sel, input logic [6:0] seg, input int n);
    DIGIT_SELECT = sel;
    SEGMENTS = seg;
    repeat (n) @(negedge CLK);
  endtask

  // Idle with select high, tens phase, then ones phase (optionally starting
  // with a short glitch pattern). rise_cyc marks the select rise.
  task automatic send_frame(input logic [6:0] tp, input logic [6:0] op,
                            input int g, input logic [6:0] gp, input int len);
    hold(1'b1, 7'd0, 6);
    hold(1'b0, tp, len);
    rise_cyc = cyc;
    if (g > 0) hold(1'b1, gp, g);
    hold(1'b1, op, len);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (DATA_OUT !== 8'd0) begin
      n_fails++; $display("FAIL reset_data_out got %0d want 0", DATA_OUT);
    end
    n_checks++;
    if (DATA_VALID !== 1'b0) begin
      n_fails++; $display("FAIL reset_valid got %b want 0", DATA_VALID);
    end
    n_checks++;
    if (SEG_ERROR !== 1'b0) begin
      n_fails++; $display("FAIL reset_seg_error got %b want 0", SEG_ERROR);
    end
    n_checks++;
    if (STALE !== 1'b0) begin
      n_fails++; $display("FAIL reset_stale got %b want 0", STALE);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Must directly follow test_reset: counts cycles from the reset release.
  task automatic test_stale();
    int highs;
    int v0;
`ifdef DISPLAY_DECODER_STALE_EN
    repeat (TO - 1) @(posedge CLK);
    #1;
    n_checks++;
    if (STALE !== 1'b0) begin
      n_fails++; $display("FAIL stale_early got %b want 0 at cycle %0d", STALE, TO - 1);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (STALE !== 1'b1) begin
      n_fails++; $display("FAIL stale_rise got %b want 1 at cycle %0d", STALE, TO);
    end
    highs = 0;
`else
    highs = 0;
    repeat (TO + 200) begin
      @(posedge CLK);
      #1;
      if (STALE !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) begin
      n_fails++; $display("FAIL stale_tied got %0d high cycles want 0", highs);
    end
`endif
    @(negedge CLK);
    v0 = valid_cnt;
    send_frame(SEG_TAB[0], SEG_TAB[5], 0, 7'd0, 30);
    model_data = 5;
    n_checks++;
    if (valid_cnt - v0 != 1 || DATA_OUT !== 8'd5) begin
      n_fails++; $display("FAIL stale_frame got valids=%0d data=%0d want 1/5", valid_cnt - v0, DATA_OUT);
    end
    n_checks++;
    if (STALE !== 1'b0) begin
      n_fails++; $display("FAIL stale_clear got %b want 0", STALE);
    end
  endtask

  task automatic test_basic_42();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(SEG_TAB[4], SEG_TAB[2], 0, 7'd0, 100);
    model_data = 42;
    n_checks++;
    if (valid_cnt - v0 != 1) begin
      n_fails++; $display("FAIL basic_valid_count got %0d want 1", valid_cnt - v0);
    end
    n_checks++;
    if (DATA_OUT !== 8'd42) begin
      n_fails++; $display("FAIL basic_data got %0d want 42", DATA_OUT);
    end
    n_checks++;
    if (last_valid_cyc - rise_cyc != S + 3) begin
      n_fails++; $display("FAIL basic_latency got %0d want %0d", last_valid_cyc - rise_cyc, S + 3);
    end
    n_checks++;
    if (err_cnt != e0) begin
      n_fails++; $display("FAIL basic_no_error got %0d want 0", err_cnt - e0);
    end
  endtask

  task automatic test_ones_error();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(SEG_TAB[4], 7'b0000000, 0, 7'd0, 40);
    n_checks++;
    if (err_cnt - e0 != 1) begin
      n_fails++; $display("FAIL ones_err_pulses got %0d want 1", err_cnt - e0);
    end
    n_checks++;
    if (valid_cnt != v0) begin
      n_fails++; $display("FAIL ones_err_valid got %0d want 0", valid_cnt - v0);
    end
    n_checks++;
    if (DATA_OUT !== 8'(model_data)) begin
      n_fails++; $display("FAIL ones_err_hold got %0d want %0d", DATA_OUT, model_data);
    end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(SEG_TAB[3], SEG_TAB[9], 2, SEG_TAB[8], 40);
    model_data = 39;
    n_checks++;
    if (valid_cnt - v0 != 1 || DATA_OUT !== 8'd39) begin
      n_fails++; $display("FAIL glitch got valids=%0d data=%0d want 1/39", valid_cnt - v0, DATA_OUT);
    end
    n_checks++;
    if (last_valid_cyc - rise_cyc != 2 + S + 3 || err_cnt != e0) begin
      n_fails++; $display("FAIL glitch_latency got %0d errs=%0d want %0d/0", last_valid_cyc - rise_cyc, err_cnt - e0, 2 + S + 3);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    v0 = valid_cnt;
    hold(1'b1, 7'd0, 6);
    hold(1'b0, SEG_TAB[7], 40);
    RST_N = 1'b0;
    hold(1'b0, SEG_TAB[7], 3);
    RST_N = 1'b1;
    hold(1'b1, SEG_TAB[5], 40);
    model_data = 0;
    n_checks++;
    if (valid_cnt != v0 || DATA_OUT !== 8'd0) begin
      n_fails++; $display("FAIL reset_mid got valids=%0d data=%0d want 0/0", valid_cnt - v0, DATA_OUT);
    end
    send_frame(SEG_TAB[1], SEG_TAB[3], 0, 7'd0, 40);
    model_data = 13;
    n_checks++;
    if (valid_cnt - v0 != 1 || DATA_OUT !== 8'd13) begin
      n_fails++; $display("FAIL reset_then_13 got valids=%0d data=%0d want 1/13", valid_cnt - v0, DATA_OUT);
    end
  endtask

  task automatic test_no_tens();
    int v0, e0;
    RST_N = 1'b0;
    hold(1'b1, SEG_TAB[6], 3);
    v0 = valid_cnt; e0 = err_cnt;
    RST_N = 1'b1;
    hold(1'b1, SEG_TAB[6], 40);
    model_data = 0;
    n_checks++;
    if (valid_cnt != v0 || err_cnt != e0 || DATA_OUT !== 8'd0) begin
      n_fails++; $display("FAIL no_tens got valids=%0d errs=%0d data=%0d want 0/0/0", valid_cnt - v0, err_cnt - e0, DATA_OUT);
    end
  endtask

  task automatic test_random();
    int v0, e0, td, od, g, len, exp_valid, exp_err;
    logic [6:0] tp, op, gp;
    for (int k = 0; k < 40; k++) begin
      td = $urandom_range(0, 9);
      od = $urandom_range(0, 9);
      tp = ($urandom_range(0, 5) == 0) ? rand_illegal() : SEG_TAB[td];
      op = ($urandom_range(0, 5) == 0) ? rand_illegal() : SEG_TAB[od];
      g = $urandom_range(0, S - 2);
      gp = 7'($urandom_range(0, 127));
      if (gp == op) gp = op ^ 7'b0000001;
      len = $urandom_range(S + 4, S + 15);
      td = model_digit(tp);
      od = model_digit(op);
      if (td < 0 || od < 0) begin
        exp_valid = 0; exp_err = 1;
      end else begin
        exp_valid = 1; exp_err = 0;
        model_data = td * 10 + od;
      end
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(tp, op, g, gp, len);
      n_checks++;
      if (valid_cnt - v0 != exp_valid || err_cnt - e0 != exp_err) begin
        n_fails++; $display("FAIL rand_pulses[%0d] got valid=%0d err=%0d want %0d/%0d", k, valid_cnt - v0, err_cnt - e0, exp_valid, exp_err);
      end
      n_checks++;
      if (DATA_OUT !== 8'(model_data)) begin
        n_fails++; $display("FAIL rand_data[%0d] got %0d want %0d", k, DATA_OUT, model_data);
      end
      if (exp_valid == 1) begin
        n_checks++;
        if (last_valid_cyc - rise_cyc != g + S + 3) begin
          n_fails++; $display("FAIL rand_latency[%0d] got %0d want %0d", k, last_valid_cyc - rise_cyc, g + S + 3);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stale();
    test_basic_42();
    test_ones_error();
    test_glitch();
    test_reset_mid_frame();
    test_no_tens();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
